// File: rtl/wb_lane_collector_pkg.sv
// wb_lane_collector_pkg: shared state codes, lane count and default widths for the write-back lane collector.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
package wb_lane_collector_pkg;

   localparam int WB_NUM_LANES  = 4;
   localparam int WB_DEF_DATA_W = 32;
   localparam int WB_DEF_REG_AW = 5;

   typedef enum logic [1:0] {
      WB_IDLE    = 2'd0,
      WB_COLLECT = 2'd1,
      WB_WRITE   = 2'd2
   } wb_state_t;

   // A group is complete once everything already held plus everything
   // arriving this cycle covers the expected lane set.
   function automatic logic group_complete(
      input logic [WB_NUM_LANES-1:0] captured,
      input logic [WB_NUM_LANES-1:0] fresh,
      input logic [WB_NUM_LANES-1:0] mask
   );
      return ((captured | fresh) == mask);
   endfunction

endpackage

// File: rtl/wb_lane_slot.sv
// wb_lane_slot: one lane's result register, captured flag and capture/stray classification.
// Latency: strobe in cycle t -> data_q/captured updated at the end of t.
// Backpressure: none; a strobe that cannot be taken is reported on stray and dropped.
// Ports: clear (start of group), expected (lane wanted now), strobe/data (lane result),
//        captured/data_q (held state), capture (taken this cycle), stray (rejected this cycle).
module wb_lane_slot
   import wb_lane_collector_pkg::*;
#(
   parameter int DATA_W = WB_DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              expected,
   input  logic              strobe,
   input  logic [DATA_W-1:0] data,
   output logic              captured,
   output logic              capture,
   output logic              stray,
   output logic [DATA_W-1:0] data_q
);

   // Only the first strobe of an expected lane is taken; duplicates and
   // unexpected lanes are flagged without touching the stored value.
   assign capture = strobe & expected & ~captured;
   assign stray   = strobe & ~capture;

   // clear and capture never coincide: clear fires on descriptor accept,
   // which happens outside COLLECT where expected is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         captured <= 1'b0;
         data_q   <= '0;
      end else if (clear) begin
         captured <= 1'b0;
         data_q   <= '0;
      end else if (capture) begin
         captured <= 1'b1;
         data_q   <= data;
      end
   end

endmodule

// File: rtl/wb_lane_collector.sv
// wb_lane_collector: latches a write-back group descriptor, gathers up to four out-of-order lane results, presents the group.
// Latency: accept in t -> COLLECT from t+1; last lane strobe in t -> wb_valid in t+1; forced completion TIMEOUT cycles after COLLECT entry.
// Backpressure: wb_ready low holds WRITE with all outputs frozen; lane strobes are never stalled and late/stray ones set err_unexpected.
// Ports: issue_valid/issue_ready + issue_rd/issue_lane_mask/issue_en_sat (descriptor in); lane_valid/lane_data (results in);
//        wb_valid/wb_ready + wb_rd/wb_lane_mask/wb_en_sat/data_res_0..3 (group out); err_unexpected/err_timeout (sticky).
module wb_lane_collector
   import wb_lane_collector_pkg::*;
#(
   parameter int DATA_W  = WB_DEF_DATA_W,
   parameter int REG_AW  = WB_DEF_REG_AW,
   parameter int TIMEOUT = 255
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           issue_valid,
   output logic                           issue_ready,
   input  logic [REG_AW-1:0]              issue_rd,
   input  logic [WB_NUM_LANES-1:0]        issue_lane_mask,
   input  logic                           issue_en_sat,
   input  logic [WB_NUM_LANES-1:0]        lane_valid,
   input  logic [WB_NUM_LANES*DATA_W-1:0] lane_data,
   output logic                           wb_valid,
   input  logic                           wb_ready,
   output logic [REG_AW-1:0]              wb_rd,
   output logic [WB_NUM_LANES-1:0]        wb_lane_mask,
   output logic                           wb_en_sat,
   output logic [DATA_W-1:0]              data_res_0,
   output logic [DATA_W-1:0]              data_res_1,
   output logic [DATA_W-1:0]              data_res_2,
   output logic [DATA_W-1:0]              data_res_3,
   output logic                           err_unexpected,
   output logic                           err_timeout
);

   // Counter must be able to hold TIMEOUT-1 even when TIMEOUT is 1.
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   wb_state_t                state_q;
   wb_state_t                state_d;
   logic [CNT_W-1:0]         cnt_q;
   logic [REG_AW-1:0]        rd_q;
   logic [WB_NUM_LANES-1:0]  lane_mask_q;
   logic                     en_sat_q;

   logic                     issue_fire;
   logic                     in_collect;
   logic                     all_done;
   logic                     cnt_at_limit;
   logic                     timed_out;
   logic [WB_NUM_LANES-1:0]  cap_vec;
   logic [WB_NUM_LANES-1:0]  cap_new;
   logic [WB_NUM_LANES-1:0]  stray_vec;
   logic [DATA_W-1:0]        slot_dat [WB_NUM_LANES];

   assign issue_fire   = issue_valid & issue_ready;
   assign in_collect   = (state_q == WB_COLLECT);
   assign all_done     = group_complete(cap_vec, cap_new, lane_mask_q);
   assign cnt_at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));
   // Completion in the last allowed cycle wins over the timeout.
   assign timed_out    = in_collect & ~all_done & cnt_at_limit;

   // ---------------------------------------------------------------
   // Lane slots
   // ---------------------------------------------------------------
   for (genvar i = 0; i < WB_NUM_LANES; i++) begin : g_slot
      wb_lane_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .clear    (issue_fire),
         .expected (in_collect & lane_mask_q[i]),
         .strobe   (lane_valid[i]),
         .data     (lane_data[DATA_W*i +: DATA_W]),
         .captured (cap_vec[i]),
         .capture  (cap_new[i]),
         .stray    (stray_vec[i]),
         .data_q   (slot_dat[i])
      );
   end

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_IDLE: begin
            // An empty mask is accepted and dropped without a write.
            if (issue_fire) begin
               state_d = (issue_lane_mask != '0) ? WB_COLLECT : WB_IDLE;
            end
         end
         WB_COLLECT: begin
            if (all_done || cnt_at_limit) begin
               state_d = WB_WRITE;
            end
         end
         WB_WRITE: begin
            // The handshake cycle may also accept the next descriptor.
            if (wb_ready) begin
               state_d = (issue_fire && (issue_lane_mask != '0)) ? WB_COLLECT : WB_IDLE;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------
   always_comb begin
      issue_ready = 1'b0;
      wb_valid    = 1'b0;
      case (state_q)
         WB_IDLE: begin
            issue_ready = 1'b1;
         end
         WB_WRITE: begin
            wb_valid    = 1'b1;
            issue_ready = wb_ready;
         end
         default: begin
            issue_ready = 1'b0;
            wb_valid    = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Descriptor, timeout counter and sticky error flags
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q        <= '0;
         lane_mask_q <= '0;
         en_sat_q    <= 1'b0;
      end else if (issue_fire) begin
         rd_q        <= issue_rd;
         lane_mask_q <= issue_lane_mask;
         en_sat_q    <= issue_en_sat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (issue_fire) begin
         cnt_q <= '0;
      end else if (in_collect) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_unexpected <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         if (|stray_vec) begin
            err_unexpected <= 1'b1;
         end
         if (timed_out) begin
            err_timeout <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Group outputs: all straight from flops, frozen while in WRITE.
   // ---------------------------------------------------------------
   assign wb_rd        = rd_q;
   assign wb_lane_mask = cap_vec;
   assign wb_en_sat    = en_sat_q;
   assign data_res_0   = slot_dat[0];
   assign data_res_1   = slot_dat[1];
   assign data_res_2   = slot_dat[2];
   assign data_res_3   = slot_dat[3];

endmodule

// File: tb/tb_wb_lane_collector.sv
module tb_wb_lane_collector;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int TO = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           issue_valid;
   logic           issue_ready;
   logic [AW-1:0]  issue_rd;
   logic [3:0]     issue_lane_mask;
   logic           issue_en_sat;
   logic [3:0]     lane_valid;
   logic [4*DW-1:0] lane_data;
   logic           wb_valid;
   logic           wb_ready;
   logic [AW-1:0]  wb_rd;
   logic [3:0]     wb_lane_mask;
   logic           wb_en_sat;
   logic [DW-1:0]  data_res_0;
   logic [DW-1:0]  data_res_1;
   logic [DW-1:0]  data_res_2;
   logic [DW-1:0]  data_res_3;
   logic           err_unexpected;
   logic           err_timeout;

   wb_lane_collector #(
      .DATA_W  (DW),
      .REG_AW  (AW),
      .TIMEOUT (TO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .issue_valid     (issue_valid),
      .issue_ready     (issue_ready),
      .issue_rd        (issue_rd),
      .issue_lane_mask (issue_lane_mask),
      .issue_en_sat    (issue_en_sat),
      .lane_valid      (lane_valid),
      .lane_data       (lane_data),
      .wb_valid        (wb_valid),
      .wb_ready        (wb_ready),
      .wb_rd           (wb_rd),
      .wb_lane_mask    (wb_lane_mask),
      .wb_en_sat       (wb_en_sat),
      .data_res_0      (data_res_0),
      .data_res_1      (data_res_1),
      .data_res_2      (data_res_2),
      .data_res_3      (data_res_3),
      .err_unexpected  (err_unexpected),
      .err_timeout     (err_timeout)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Current group as issued, and the strobe plan applied from COLLECT entry on.
   logic [AW-1:0]   g_rd;
   logic [3:0]      g_mask;
   logic            g_sat;
   logic [3:0]      plan_v [$];
   logic [4*DW-1:0] plan_d [$];

   // Expected results from the reference model.
   logic [3:0]      exp_cap;
   logic [DW-1:0]   exp_dat [4];
   logic            exp_unexp;
   logic            exp_to;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4*DW-1:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic add_step(input logic [3:0] v, input logic [4*DW-1:0] d);
      plan_v.push_back(v);
      plan_d.push_back(d);
   endtask

   // Single lane strobe carrying the recognisable value 3F00_0000 + lane.
   task automatic add_lane(input int l);
      logic [4*DW-1:0] d;
      d = rnd128();
      d[32*l +: 32] = 32'h3F00_0000 + 32'(l);
      add_step(4'(1 << l), d);
   endtask

   // Reference model: walk the plan cycle by cycle from COLLECT entry.
   // A lane counts on its first strobe while the group is still open and
   // the lane is wanted; anything else is stray. The group closes one cycle
   // after its last wanted lane, or TO cycles after entry if never complete.
   task automatic predict(output int done);
      exp_cap = '0;
      for (int i = 0; i < 4; i++) exp_dat[i] = '0;
      done = -1;
      for (int k = 0; k < plan_v.size(); k++) begin
         for (int i = 0; i < 4; i++) begin
            if (plan_v[k][i]) begin
               if (done < 0 && g_mask[i] && !exp_cap[i]) begin
                  exp_cap[i] = 1'b1;
                  exp_dat[i] = plan_d[k][32*i +: 32];
               end else begin
                  exp_unexp = 1'b1;
               end
            end
         end
         if (done < 0) begin
            if (exp_cap == g_mask) done = k + 1;
            else if (k == TO - 1) begin
               done   = TO;
               exp_to = 1'b1;
            end
         end
      end
      if (done < 0) begin
         done   = TO;
         exp_to = 1'b1;
      end
   endtask

   task automatic start(input logic [AW-1:0] rd, input logic [3:0] mask, input logic sat);
      g_rd = rd; g_mask = mask; g_sat = sat;
      issue_valid = 1'b1; issue_rd = rd; issue_lane_mask = mask; issue_en_sat = sat;
      #1 chk("issue_ready_idle", 32'(issue_ready), 32'd1);
      tick();
      issue_valid = 1'b0;
   endtask

   // Runs the plan with wb_ready low, checking wb_valid each cycle, then the group.
   task automatic collect();
      int done;
      int n;
      predict(done);
      n = (plan_v.size() > done) ? plan_v.size() : done;
      for (int k = 0; k < n; k++) begin
         if (k < plan_v.size()) begin
            lane_valid = plan_v[k];
            lane_data  = plan_d[k];
         end else begin
            lane_valid = '0;
            lane_data  = rnd128();
         end
         tick();
         chk("wb_valid_timing", 32'(wb_valid), 32'(k + 1 >= done));
         if (k + 1 >= done) chk("wb_lane_mask_hold", 32'(wb_lane_mask), 32'(exp_cap));
      end
      lane_valid = '0;
      chk("wb_rd", 32'(wb_rd), 32'(g_rd));
      chk("wb_lane_mask", 32'(wb_lane_mask), 32'(exp_cap));
      chk("wb_en_sat", 32'(wb_en_sat), 32'(g_sat));
      chk("data_res_0", data_res_0, exp_dat[0]);
      chk("data_res_1", data_res_1, exp_dat[1]);
      chk("data_res_2", data_res_2, exp_dat[2]);
      chk("data_res_3", data_res_3, exp_dat[3]);
      chk("err_unexpected", 32'(err_unexpected), 32'(exp_unexp));
      chk("err_timeout", 32'(err_timeout), 32'(exp_to));
      chk("issue_ready_held", 32'(issue_ready), 32'd0);
      plan_v.delete();
      plan_d.delete();
   endtask

   // Handshake the group; optionally offer the next descriptor in the same cycle.
   task automatic finish(input bit chain, input logic [AW-1:0] rd, input logic [3:0] mask,
                         input logic sat);
      wb_ready = 1'b1;
      if (chain) begin
         issue_valid = 1'b1; issue_rd = rd; issue_lane_mask = mask; issue_en_sat = sat;
      end
      #1 chk("issue_ready_write", 32'(issue_ready), 32'd1);
      tick();
      wb_ready = 1'b0;
      issue_valid = 1'b0;
      #1;
      chk("wb_valid_after_hs", 32'(wb_valid), 32'd0);
      chk("issue_ready_after_hs", 32'(issue_ready), 32'(!(chain && mask != 4'd0)));
      if (chain) begin
         g_rd = rd; g_mask = mask; g_sat = sat;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
      chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
      chk({tag, "_wb_lane_mask"}, 32'(wb_lane_mask), 32'd0);
      chk({tag, "_wb_en_sat"}, 32'(wb_en_sat), 32'd0);
      chk({tag, "_data_res_0"}, data_res_0, 32'd0);
      chk({tag, "_data_res_1"}, data_res_1, 32'd0);
      chk({tag, "_data_res_2"}, data_res_2, 32'd0);
      chk({tag, "_data_res_3"}, data_res_3, 32'd0);
      chk({tag, "_err_unexpected"}, 32'(err_unexpected), 32'd0);
      chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      issue_valid = 1'b0; issue_rd = '0; issue_lane_mask = '0; issue_en_sat = 1'b0;
      lane_valid = '0; lane_data = '0; wb_ready = 1'b0;
      exp_unexp = 1'b0; exp_to = 1'b0;

      // Reset state.
      repeat (3) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();
      chk("issue_ready_after_reset", 32'(issue_ready), 32'd1);

      // Full group, lanes arrive 2,0,3,1 on consecutive cycles.
      start(5'd7, 4'hF, 1'b1);
      add_lane(2); add_lane(0); add_lane(3); add_lane(1);
      collect();
      finish(1'b0, '0, '0, 1'b0);

      // Empty mask: dropped, ready stays high, next descriptor taken next cycle.
      start(5'd9, 4'h0, 1'b1);
      chk("mask0_no_valid", 32'(wb_valid), 32'd0);
      chk("mask0_issue_ready", 32'(issue_ready), 32'd1);
      start(5'd10, 4'b0011, 1'b0);
      add_step(4'b0011, rnd128());
      collect();
      finish(1'b0, '0, '0, 1'b0);

      // Asynchronous reset mid-COLLECT with lanes 0 and 1 already captured.
      start(5'd3, 4'hF, 1'b1);
      lane_valid = 4'b0001; lane_data = rnd128(); tick();
      lane_valid = 4'b0010; lane_data = rnd128(); tick();
      lane_valid = '0;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midrst");
      #2 rst_n = 1'b1;
      exp_unexp = 1'b0; exp_to = 1'b0;
      tick();
      chk("issue_ready_after_midrst", 32'(issue_ready), 32'd1);
      start(5'd4, 4'hF, 1'b0);
      add_lane(1); add_lane(3);
      add_step(4'b0101, rnd128());
      collect();
      finish(1'b0, '0, '0, 1'b0);

      // mask 0101 with all four lanes strobed together.
      start(5'd5, 4'b0101, 1'b0);
      add_step(4'hF, rnd128());
      collect();
      finish(1'b0, '0, '0, 1'b0);

      // Timeout: only lane 3 of a full mask ever arrives.
      start(5'd12, 4'hF, 1'b0);
      add_lane(3);
      collect();
      finish(1'b0, '0, '0, 1'b0);

      // WRITE held for 5 cycles while lane 0 keeps strobing, then a
      // back-to-back descriptor rides the handshake cycle.
      start(5'd20, 4'hF, 1'b1);
      add_step(4'hF, rnd128());
      for (int i = 0; i < 5; i++) add_step(4'b0001, rnd128());
      collect();
      finish(1'b1, 5'd21, 4'b0110, 1'b1);
      add_step(4'b0110, rnd128());
      collect();
      finish(1'b0, '0, '0, 1'b0);

      // Randomized groups.
      for (int g = 0; g < 20; g++) begin
         start(AW'($urandom_range(0, 31)), 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
         for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
            add_step(4'($urandom_range(0, 15)), rnd128());
         end
         collect();
         finish(1'b0, '0, '0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
